// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider (DIV/DIVU) for the EX stage.
// Returns {remainder, quotient} 33 edges after acceptance and holds the result
// until the requester drops start_i. annul_i aborts an in-flight operation.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] work_q, work_d;     // {partial remainder, dividend/quotient}
  logic [31:0] dvsr_q, dvsr_d;     // divisor magnitude
  logic        neg_quot_q, neg_quot_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] a_mag, b_mag;
  logic [32:0] upper;
  logic [31:0] trial;
  logic        ge;
  logic [31:0] quot, rem;

  // Operand magnitudes, one restoring step, and sign-corrected final values
  always_comb begin
    a_mag = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    b_mag = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    // Upper 33 bits after the left shift; the remainder after a successful
    // subtract is below the divisor so 32 bits hold it exactly.
    upper = work_q[63:31];
    ge    = (upper >= {1'b0, dvsr_q});
    trial = upper[31:0] - dvsr_q;
    quot  = neg_quot_q ? (~work_q[31:0] + 32'd1) : work_q[31:0];
    rem   = neg_rem_q  ? (~work_q[63:32] + 32'd1) : work_q[63:32];
  end

  // Next-state and datapath control
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    result_d   = result_q;
    ready_d    = ready_q;
    case (state_q)
      FREE: begin
        result_d = 64'h0;
        ready_d  = 1'b0;
        if (start_i && !annul_i) begin
          work_d     = {32'h0, a_mag};
          dvsr_d     = b_mag;
          neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d  = signed_div_i && opdata1_i[31];
          cnt_d      = 6'd0;
          state_d    = (opdata2_i == 32'h0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        result_d = 64'h0;
        if (annul_i) begin
          state_d = FREE;
          ready_d = 1'b0;
        end else begin
          state_d = END;
          ready_d = 1'b1;
        end
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          cnt_d    = 6'd0;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end else if (cnt_q == 6'd32) begin
          state_d  = END;
          result_d = {rem, quot};
          ready_d  = 1'b1;
        end else begin
          work_d = ge ? {trial, work_q[30:0], 1'b1} : {work_q[62:0], 1'b0};
          cnt_d  = cnt_q + 6'd1;
        end
      end
      END: begin
        // annul_i is ignored here; only dropping start_i releases the result
        if (!start_i) begin
          state_d  = FREE;
          result_d = 64'h0;
          ready_d  = 1'b0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      cnt_q      <= 6'd0;
      work_q     <= 64'h0;
      dvsr_q     <= 32'h0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      result_q   <= 64'h0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus annul/reset/hold sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i, opdata2_i;
  logic        start_i, annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int tests  = 0;
  int failed = 0;

  div_unit dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        sg;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Counts edges (the first one waited on is 1) until ready_o is seen high
  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!ready_o && n < 100);
  endtask

  task automatic do_div(input vec_t v);
    int n;
    @(negedge clk);
    signed_div_i = v.sg; opdata1_i = v.a; opdata2_i = v.b; start_i = 1'b1;
    @(posedge clk); #1;                       // edge 0: accepted
    @(negedge clk);
    signed_div_i = ~v.sg; opdata1_i = 32'hDEAD_BEEF; opdata2_i = 32'h0000_0003;
    wait_ready(n);
    chk({v.name, " latency"}, 64'(n), 64'(v.lat));
    chk({v.name, " result"}, result_o, v.exp);
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      annul_i = (i == 1);                     // must be ignored while held
      @(posedge clk); #1;
      chk({v.name, " hold"}, {63'h0, ready_o} ^ result_o, v.exp ^ 64'h1);
    end
    @(negedge clk);
    start_i = 1'b0; annul_i = 1'b0;
    @(posedge clk); #1;
    chk({v.name, " release"}, {63'h0, ready_o} | result_o, 64'h0);
  endtask

  initial begin
    int n, rises;
    vecs[0] = '{"u100_7",   1'b0, 32'd100,       32'd7,         {32'd2, 32'd14},                33, 0};
    vecs[1] = '{"s-7_2",    1'b1, 32'hFFFF_FFF9, 32'h2,         {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33, 0};
    vecs[2] = '{"u-7_2",    1'b0, 32'hFFFF_FFF9, 32'h2,         {32'h1, 32'h7FFF_FFFC},         33, 0};
    vecs[3] = '{"div0",     1'b1, 32'h1234_5678, 32'h0,         64'h0,                          1,  2};
    vecs[4] = '{"s_ovf",    1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000},         33, 5};
    vecs[5] = '{"uFFFF_1",  1'b0, 32'hFFFF_FFFF, 32'h1,         {32'h0, 32'hFFFF_FFFF},         33, 0};
    vecs[6] = '{"s7_-2",    1'b1, 32'd7,         32'hFFFF_FFFE, {32'h1, 32'hFFFF_FFFD},         33, 0};
    vecs[7] = '{"s-100_-7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},        33, 0};
    vecs[8] = '{"u5_10",    1'b0, 32'd5,         32'd10,        {32'd5, 32'd0},                 33, 0};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; signed_div_i = 1'b0;
    opdata1_i = 32'h0; opdata2_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ready", {63'h0, ready_o}, 64'h0);
    chk("reset result", result_o, 64'h0);
    @(negedge clk); rst = 1'b0;

    foreach (vecs[i]) do_div(vecs[i]);

    // annul at edge 10 of ON, start dropped with it
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);                           // edge 0
    repeat (9) @(posedge clk);                // edges 1..9
    @(negedge clk); annul_i = 1'b1; start_i = 1'b0;
    @(posedge clk); #1;                       // edge 10
    chk("annul flush", {63'h0, ready_o} | result_o, 64'h0);
    @(negedge clk); annul_i = 1'b0;
    rises = 0;
    repeat (40) begin @(posedge clk); #1; if (ready_o) rises++; end
    chk("annul no result", 64'(rises), 64'h0);
    do_div(vecs[0]);

    // reset at edge 20 of ON with start held throughout
    @(negedge clk);
    signed_div_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
    @(posedge clk);                           // edge 0
    repeat (19) @(posedge clk);               // edges 1..19
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;                       // edge 20
    chk("rst mid ready", {63'h0, ready_o}, 64'h0);
    chk("rst mid result", result_o, 64'h0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    wait_ready(n);                            // first edge waited on is edge 0
    chk("rst restart latency", 64'(n - 1), 64'd33);
    chk("rst restart result", result_o, {32'd2, 32'd14});
    @(negedge clk); start_i = 1'b0;
    @(posedge clk); #1;
    chk("rst restart release", {63'h0, ready_o}, 64'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL use reset rst, synchronous, active-high.
REQ-002 The port list SHALL be, in order:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request from EX; held high until the result is consumed
- annul_i  in  1  cancel in-flight division (pipeline flush)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; consumed by EX as {hi, lo}
- ready_o  out  1  result_o valid

Function
REQ-003 The block SHALL implement four states:
- FREE: idle
- BYZERO: divisor was zero
- ON: iterating
- END: result held
REQ-004 In FREE, with start_i=1 and annul_i=0 at an edge, the block SHALL latch opdata1_i, opdata2_i and signed_div_i.
- It SHALL go to BYZERO if opdata2_i==0, else to ON with iteration counter cnt=0.
REQ-005 In FREE, if start_i=0 or annul_i=1, the block SHALL stay in FREE.
REQ-006 On entering ON in signed mode, each negative operand SHALL be replaced by its two's complement (magnitude). In unsigned mode, operands SHALL be used unchanged.
REQ-007 In ON with cnt<32, each edge SHALL perform one restoring-division step.
- Shift the {partial remainder, dividend} register left by one bit.
- Trial-subtract the divisor magnitude from the upper 33 bits.
- If the difference is non-negative, keep it and shift in quotient bit 1; otherwise restore and shift in 0.
- Increment cnt.
REQ-008 In ON with cnt==32, the block SHALL apply sign correction, load result_o and go to END.
- Signed mode: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative.
REQ-009 Latency SHALL be measured from the acceptance edge (edge 0).
- Non-zero divisor: ready_o=1 after edge 33.
- Zero divisor: ready_o=1 after edge 1.
REQ-010 BYZERO SHALL go to END on the next edge with result_o=64'h0.
REQ-011 In END, ready_o SHALL be 1 and result_o SHALL hold stable while start_i=1.
REQ-012 In END, when start_i=0 at an edge, the block SHALL go to FREE with ready_o=0 and result_o=0 on that edge.
- A new request SHALL NOT be accepted until the block is in FREE.
REQ-013 annul_i=1 at any edge in ON or BYZERO SHALL return the block to FREE with ready_o=0 and result_o=0.
- No result SHALL be produced.
- annul_i SHALL have priority over the cnt==32 completion.
REQ-014 annul_i in END SHALL be ignored; only start_i=0 releases END.
REQ-015 Operand changes on opdata1_i/opdata2_i/signed_div_i after the acceptance edge SHALL NOT affect the result.
REQ-016 Signed overflow (0x80000000 / 0xFFFFFFFF) SHALL yield quotient 0x80000000, remainder 0 (wrap, no trap).
REQ-017 ready_o and result_o SHALL be registered outputs, with no combinational path from inputs.

Reset
REQ-018 While rst=1 at an edge, the block SHALL go to FREE with ready_o=0, result_o=64'h0, cnt=0 and internal operand registers cleared.
- This SHALL hold regardless of state, including mid-iteration.
REQ-019 After rst deasserts, the block SHALL accept a request on the first edge where start_i=1.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- Unsigned 100 / 7, start held -> ready_o=1 after edge 33; result_o={32'd2, 32'd14}; ready_o not asserted before edge 33.
- Signed -7 / 2 (0xFFFFFFF9, 0x2) -> result_o={0xFFFFFFFF, 0xFFFFFFFD}; the same operands unsigned -> {0x1, 0x7FFFFFFC}.
- Divisor 0 (any dividend) -> ready_o=1 after edge 1, result_o=0; drop start_i -> FREE next edge, ready_o=0.
- annul_i pulsed at edge 10 of ON -> FREE at edge 10; ready_o never rises; a new request 100/7 then completes correctly in 33 edges.
- rst asserted at edge 20 of ON -> ready_o=0, result_o=0 next edge; start_i held through the reset restarts the division at the first edge after rst falls.
- Signed 0x80000000 / 0xFFFFFFFF -> {0x0, 0x80000000}; with start_i held 5 extra cycles in END, result_o stays stable.
